spi_txn_arbiter: RTL and testbench
==================================

// Module: spi_txn_arbiter
// PURPOSE
//  Shares the single SPI master port (clk/MOSI/MISO, chip selects CS1..CS3) between NUM_REQ
//  on-chip requesters. Arbitrates, then sequences one 16-bit transaction: 8-bit command byte,
//  then 8-bit data byte, MSB first.
//  Generates sclk, drives the active-low chip selects, and returns the captured MISO byte.
// PARAMETERS
//  NUM_REQ  3  number of requesters (1..8)
//  CLK_DIV  1  sclk half-period in clk cycles (>=1); sclk = clk/(2*CLK_DIV)
// PORTS
//  clk        in   1          system clock, all logic on posedge
//  rst        in   1          synchronous, active-high reset
//  req        in   NUM_REQ    request per requester; held high until its gnt
//  req_op     in   2*NUM_REQ  op per requester: 01 read, 10 write, 11 exchange, 00 illegal
//  req_slv    in   2*NUM_REQ  target slave per requester: 1..3 (0 illegal)
//  req_wdata  in   8*NUM_REQ  data byte per requester
//  gnt        out  NUM_REQ    1-cycle pulse: request accepted, fields latched this edge
//  done       out  NUM_REQ    1-cycle pulse: transaction of that requester finished
//  err        out  NUM_REQ    1-cycle pulse: request rejected (illegal op or slave id)
//  rdata      out  8          captured data byte, valid in the done cycle, held until next done
//  busy       out  1          high from gnt through done
//  sclk       out  1          SPI clock, idle low
//  CS1,CS2,CS3 out 1 each     active-low chip selects, idle high
//  MOSI       out  1          serial out
//  MISO       in   1          serial in
// BEHAVIOUR
//  Reset: gnt=done=err=0, rdata=8'h00, busy=0, sclk=0, CS1..3=1, MOSI=0, state IDLE, RR ptr=0.
//   Reset mid-transaction aborts on that edge: CS high, sclk low, no done.
//  FSM IDLE->SETUP->SHIFT->HOLD->IDLE.
//  IDLE: any req -> winner i selected; next edge gnt[i]=1 and op/slv/wdata latched.
//   Illegal op or slave: err[i]=1 instead of gnt, stay IDLE, no CS activity.
//   Legal request: CSn[slv]=0, busy=1, go SETUP.
//  SETUP: CLK_DIV cycles, sclk=0, MOSI=cmd[7].
//  SHIFT: 16 sclk periods. Rising edge: sample MISO. Falling edge: shift to next MOSI bit.
//   Bits 0..7 carry cmd = {6'b0,op}; bits 8..15 carry the data byte.
//   Data byte = wdata for write/exchange, 8'h00 for read.
//  HOLD: CLK_DIV cycles, sclk=0, CS still low.
//   Exit edge: CS high, done[i]=1, busy=0, rdata updated, go IDLE.
//   rdata = MISO bits 8..15 for read/exchange; 8'h00 for write.
//  Latency: gnt -> done = 34*CLK_DIV clk cycles. CS stays high >=1 cycle between transactions.
//  Only one transaction in flight. req changes during busy are ignored until IDLE.
//  Simultaneous requests in IDLE resolved per CONFIGURATION.
//   RR pointer advances to winner+1 (mod NUM_REQ) on gnt or err.
// CONFIGURATION
//  SPI_ARB_RR_EN defined: round-robin; search starts at pointer, wraps past NUM_REQ-1 to 0.
//  SPI_ARB_RR_EN undefined: fixed priority, lowest index wins; pointer logic removed.
// TESTING
//  1 Single write: req0 op=10 slv=1 wdata=8'h4D -> CS1 low 34 cycles.
//    MOSI bits = 00000010_01001101; done[0]; rdata=8'h00.
//  2 Read: req1 op=01 slv=2, slave drives 8'hA5 -> MOSI data byte 8'h00.
//    done[1], rdata=8'hA5; CS1, CS3 stay high.
//  3 Exchange: req2 op=11 slv=3 wdata=8'h3C, slave returns 8'hC3.
//    -> MOSI 00000011_00111100, rdata=8'hC3.
//  4 All req high, 3 transactions:
//    RR_EN: gnt order 0,1,2.
//    No RR_EN: req0 kept high -> gnt 0,0,0.
//  5 Illegal: req0 op=00, then slv=0 -> err[0] each time, no gnt, CS1..3 stay high.
//  6 rst pulsed at sclk edge 9 of a write -> CS high, sclk 0 next edge, no done.
//    Next request completes normally.

Source files
------------

// File: rtl/spi_txn_arbiter_if.sv
// Request/grant bus and SPI pins of spi_txn_arbiter, grouped as one interface.
// slave = arbiter side, master = requesters plus the external SPI slave device.
interface spi_txn_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   req;
    logic [2*NUM_REQ-1:0] req_op;
    logic [2*NUM_REQ-1:0] req_slv;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic [NUM_REQ-1:0]   err;
    logic [7:0]           rdata;
    logic                 busy;
    logic                 sclk;
    logic                 CS1;
    logic                 CS2;
    logic                 CS3;
    logic                 MOSI;
    logic                 MISO;

    modport slave (
        input  req, req_op, req_slv, req_wdata, MISO,
        output gnt, done, err, rdata, busy, sclk, CS1, CS2, CS3, MOSI
    );

    modport master (
        output req, req_op, req_slv, req_wdata, MISO,
        input  gnt, done, err, rdata, busy, sclk, CS1, CS2, CS3, MOSI
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Arbitrates NUM_REQ requesters onto one SPI port; runs a 16-bit cmd+data transaction.
// Define SPI_ARB_RR_EN for round-robin arbitration, otherwise fixed lowest-index priority.
module spi_txn_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int CLK_DIV = 1
) (
    input logic            clk,
    input logic            rst,
    spi_txn_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      div_q, div_d;
    logic [4:0]         half_q, half_d;
    logic               sclk_q, sclk_d;
    logic [2:0]         csn_q, csn_d;
    logic [15:0]        tx_q, tx_d;
    logic [7:0]         rx_q, rx_d;
    logic [7:0]         rdata_q, rdata_d;
    logic [1:0]         op_q, op_d;
    logic [IW-1:0]      own_q, own_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic               busy_q, busy_d;

    logic               win_vld;
    logic [IW-1:0]      win_idx;
    logic [1:0]         win_op;
    logic [1:0]         win_slv;
    logic [7:0]         win_wdata;
    logic               phase_end;

`ifdef SPI_ARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;

    // Search starts at the pointer and wraps past NUM_REQ-1 back to 0.
    always_comb begin : arb_rr
        int unsigned idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_vld && bus.req[idx]) begin
                win_vld = 1'b1;
                win_idx = IW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && win_vld)
            ptr_d = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    always_comb begin : arb_fixed
        win_vld = 1'b0;
        win_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!win_vld && bus.req[k]) begin
                win_vld = 1'b1;
                win_idx = IW'(k);
            end
        end
    end
`endif

    assign win_op    = bus.req_op[2*win_idx +: 2];
    assign win_slv   = bus.req_slv[2*win_idx +: 2];
    assign win_wdata = bus.req_wdata[8*win_idx +: 8];
    assign phase_end = (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        half_d  = half_q;
        sclk_d  = sclk_q;
        csn_d   = csn_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        op_d    = op_q;
        own_d   = own_q;
        busy_d  = busy_q;
        gnt_d   = '0;
        done_d  = '0;
        err_d   = '0;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    if (win_op == 2'b00 || win_slv == 2'b00) begin
                        err_d[win_idx] = 1'b1;
                    end else begin
                        gnt_d[win_idx] = 1'b1;
                        own_d   = win_idx;
                        op_d    = win_op;
                        tx_d    = {6'b0, win_op, (win_op == 2'b01) ? 8'h00 : win_wdata};
                        busy_d  = 1'b1;
                        div_d   = '0;
                        state_d = SETUP;
                        case (win_slv)
                            2'd1:    csn_d = 3'b110;
                            2'd2:    csn_d = 3'b101;
                            default: csn_d = 3'b011;
                        endcase
                    end
                end
            end
            SETUP: begin
                if (phase_end) begin
                    div_d   = '0;
                    half_d  = '0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT: begin
                // Even half-periods end on a rising sclk (sample), odd ones on falling (shift).
                if (phase_end) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    half_d = half_q + 5'd1;
                    if (!sclk_q) rx_d = {rx_q[6:0], bus.MISO};
                    else         tx_d = {tx_q[14:0], 1'b0};
                    if (half_q == 5'd31) state_d = HOLD;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (phase_end) begin
                    div_d          = '0;
                    csn_d          = '1;
                    done_d[own_q]  = 1'b1;
                    busy_d         = 1'b0;
                    rdata_d        = (op_q == 2'b10) ? 8'h00 : rx_q;
                    state_d        = IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            half_q  <= '0;
            sclk_q  <= 1'b0;
            csn_q   <= '1;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            op_q    <= '0;
            own_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            half_q  <= half_d;
            sclk_q  <= sclk_d;
            csn_q   <= csn_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            op_q    <= op_d;
            own_q   <= own_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.sclk  = sclk_q;
    assign bus.CS1   = csn_q[0];
    assign bus.CS2   = csn_q[1];
    assign bus.CS3   = csn_q[2];
    assign bus.MOSI  = tx_q[15];
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: vector table, reset/arbitration sequences and random
// traffic checked against a rule-level model of arbitration and SPI framing.
module tb_spi_txn_arbiter;
    localparam int NUM_REQ = 3;
    localparam int CLK_DIV = 2;
    localparam int LAT     = 34 * CLK_DIV;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_txn_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    spi_txn_arbiter #(.NUM_REQ(NUM_REQ), .CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int         m_ptr;
    logic [7:0] m_rdata;

    typedef struct {
        int          idx;
        logic [1:0]  op;
        logic [1:0]  slv;
        logic [7:0]  wdata;
        logic [7:0]  miso;
        logic        exp_err;
        logic [15:0] exp_mosi;
        logic [7:0]  exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout, event not seen", name);
    endtask

    function automatic int model_pick(input logic [NUM_REQ-1:0] mask, input int ptr);
`ifdef SPI_ARB_RR_EN
        for (int k = 0; k < NUM_REQ; k++)
            if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
`else
        for (int k = 0; k < NUM_REQ; k++)
            if (mask[k]) return k;
`endif
        return -1;
    endfunction

    task automatic set_req(input int idx, input logic [1:0] op, input logic [1:0] slv,
                           input logic [7:0] wdata);
        bus.req_op[2*idx +: 2]    = op;
        bus.req_slv[2*idx +: 2]   = slv;
        bus.req_wdata[8*idx +: 8] = wdata;
        bus.req[idx]              = 1'b1;
    endtask

    // Waits for the handshake of requester exp_idx, then plays SPI slave until done.
    task automatic observe(input int exp_idx, input logic exp_err, input logic [1:0] slv,
                           input logic [15:0] exp_mosi, input logic [7:0] miso_byte,
                           input logic [7:0] exp_rdata, input logic drop, input string tag);
        int          cyc;
        int          lat;
        int          rises;
        int          cs_low;
        int          bad;
        logic        seen;
        logic        prev_sclk;
        logic [15:0] mosi_got;
        logic [15:0] miso16;
        logic [7:0]  junk;
        logic [2:0]  csv;
        logic [2:0]  cs_sel;

        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.gnt != '0 || bus.err != '0) seen = 1'b1;
        end
        if (!seen) begin
            fail_timeout({tag, " handshake"});
            return;
        end
        m_ptr = (exp_idx + 1) % NUM_REQ;
        csv   = {bus.CS3, bus.CS2, bus.CS1};

        if (exp_err) begin
            check({tag, " err"}, 32'(bus.err), 32'(1 << exp_idx));
            check({tag, " no gnt on err"}, 32'(bus.gnt), 32'd0);
            if (drop) bus.req[exp_idx] = 1'b0;
            bad = (csv != 3'b111) ? 1 : 0;
            repeat (6) begin
                @(negedge clk);
                if ({bus.CS3, bus.CS2, bus.CS1} != 3'b111 || bus.sclk || bus.busy) bad++;
            end
            check({tag, " idle after err"}, 32'(bad), 32'd0);
            check({tag, " rdata held"}, 32'(bus.rdata), 32'(exp_rdata));
            return;
        end

        check({tag, " gnt"}, 32'(bus.gnt), 32'(1 << exp_idx));
        check({tag, " busy at gnt"}, 32'(bus.busy), 32'd1);
        if (drop) bus.req[exp_idx] = 1'b0;

        cs_sel   = ~(3'b001 << (slv - 2'd1));
        junk     = 8'($urandom);
        miso16   = {junk, miso_byte};
        bus.MISO = miso16[15];
        mosi_got = '0;
        rises    = 0;
        cs_low   = (csv == cs_sel) ? 1 : 0;
        bad      = (csv != cs_sel) ? 1 : 0;
        prev_sclk = bus.sclk;
        lat      = 0;
        seen     = 1'b0;
        while (!seen && lat < LAT + 20) begin
            @(negedge clk);
            lat++;
            csv = {bus.CS3, bus.CS2, bus.CS1};
            if (csv == cs_sel) cs_low++;
            else if (csv != 3'b111) bad++;
            if (bus.sclk && !prev_sclk) begin
                if (rises < 16) mosi_got[15 - rises] = bus.MOSI;
                rises++;
                if (rises < 16) bus.MISO = miso16[15 - rises];
            end
            prev_sclk = bus.sclk;
            if (bus.done != '0) seen = 1'b1;
        end
        if (!seen) begin
            fail_timeout({tag, " done"});
            return;
        end
        check({tag, " done"}, 32'(bus.done), 32'(1 << exp_idx));
        check({tag, " latency"}, 32'(lat), 32'(LAT));
        check({tag, " cs low cycles"}, 32'(cs_low), 32'(LAT));
        check({tag, " foreign cs"}, 32'(bad), 32'd0);
        check({tag, " sclk rises"}, 32'(rises), 32'd16);
        check({tag, " mosi"}, 32'(mosi_got), 32'(exp_mosi));
        check({tag, " rdata"}, 32'(bus.rdata), 32'(exp_rdata));
        check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
        check({tag, " cs released"}, 32'({bus.CS3, bus.CS2, bus.CS1}), 32'h7);
        m_rdata = exp_rdata;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t             vt[6];
        logic [NUM_REQ-1:0] mask;
        int               w;
        int               rises;
        int               cyc;
        int               bad;
        logic             prev_sclk;
        logic             seen;

        vt[0] = '{0, 2'b10, 2'd1, 8'h4D, 8'h5A, 1'b0, 16'h024D, 8'h00};
        vt[1] = '{1, 2'b01, 2'd2, 8'hFF, 8'hA5, 1'b0, 16'h0100, 8'hA5};
        vt[2] = '{2, 2'b11, 2'd3, 8'h3C, 8'hC3, 1'b0, 16'h033C, 8'hC3};
        vt[3] = '{0, 2'b00, 2'd1, 8'h11, 8'h00, 1'b1, 16'h0000, 8'hC3};
        vt[4] = '{0, 2'b10, 2'd0, 8'h22, 8'h00, 1'b1, 16'h0000, 8'hC3};
        vt[5] = '{1, 2'b11, 2'd2, 8'h00, 8'hFF, 1'b0, 16'h0300, 8'hFF};

        rst           = 1'b1;
        bus.req       = '0;
        bus.req_op    = '0;
        bus.req_slv   = '0;
        bus.req_wdata = '0;
        bus.MISO      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset gnt",   32'(bus.gnt),   32'd0);
        check("reset done",  32'(bus.done),  32'd0);
        check("reset err",   32'(bus.err),   32'd0);
        check("reset rdata", 32'(bus.rdata), 32'd0);
        check("reset busy",  32'(bus.busy),  32'd0);
        check("reset sclk",  32'(bus.sclk),  32'd0);
        check("reset cs",    32'({bus.CS3, bus.CS2, bus.CS1}), 32'h7);
        check("reset mosi",  32'(bus.MOSI),  32'd0);
        rst     = 1'b0;
        m_ptr   = 0;
        m_rdata = 8'h00;

        for (int i = 0; i < 6; i++) begin
            set_req(vt[i].idx, vt[i].op, vt[i].slv, vt[i].wdata);
            observe(vt[i].idx, vt[i].exp_err, vt[i].slv, vt[i].exp_mosi, vt[i].miso,
                    vt[i].exp_rdata, 1'b1, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a write: abort without done, then a clean transaction.
        set_req(0, 2'b10, 2'd1, 8'hE7);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            seen = bus.gnt[0];
        end
        if (!seen) fail_timeout("rst-mid gnt");
        bus.req[0] = 1'b0;
        rises     = 0;
        cyc       = 0;
        prev_sclk = bus.sclk;
        while (rises < 9 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bus.sclk && !prev_sclk) rises++;
            prev_sclk = bus.sclk;
        end
        if (rises < 9) fail_timeout("rst-mid sclk edge 9");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst-mid cs",   32'({bus.CS3, bus.CS2, bus.CS1}), 32'h7);
        check("rst-mid sclk", 32'(bus.sclk), 32'd0);
        check("rst-mid busy", 32'(bus.busy), 32'd0);
        check("rst-mid done", 32'(bus.done), 32'd0);
        m_ptr   = 0;
        m_rdata = 8'h00;
        bad     = 0;
        repeat (LAT + 10) begin
            @(negedge clk);
            if (bus.done != '0 || {bus.CS3, bus.CS2, bus.CS1} != 3'b111) bad++;
        end
        check("rst-mid quiet after abort", 32'(bad), 32'd0);
        check("rst-mid rdata cleared", 32'(bus.rdata), 32'd0);
        set_req(0, 2'b11, 2'd2, 8'h96);
        observe(0, 1'b0, 2'd2, 16'h0396, 8'h69, 8'h69, 1'b1, "post-rst");

        // All three requesting at once; in fixed priority req0 stays asserted.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'b10, 2'(i + 1), 8'(8'h10 + i));
        mask = '1;
        for (int t = 0; t < 3; t++) begin
            logic dropw;
            w = model_pick(mask, m_ptr);
`ifdef SPI_ARB_RR_EN
            dropw = 1'b1;
`else
            dropw = (w != 0);
`endif
            observe(w, 1'b0, 2'(w + 1), {8'h02, 8'(8'h10 + w)}, 8'h00, 8'h00, dropw,
                    $sformatf("all-req%0d", t));
            if (dropw) mask[w] = 1'b0;
        end
        bus.req = '0;

        for (int n = 0; n < 20; n++) begin
            int         idx;
            logic [1:0] op;
            logic [1:0] slv;
            logic [7:0] wd;
            logic [7:0] mi;
            logic       e;
            logic [7:0] er;
            idx = $urandom_range(NUM_REQ - 1, 0);
            op  = 2'($urandom_range(3, 0));
            slv = 2'($urandom_range(3, 0));
            wd  = 8'($urandom);
            mi  = 8'($urandom);
            e   = (op == 2'b00) || (slv == 2'b00);
            er  = e ? m_rdata : ((op == 2'b10) ? 8'h00 : mi);
            set_req(idx, op, slv, wd);
            observe(idx, e, slv, {6'b0, op, (op == 2'b01) ? 8'h00 : wd}, mi, er, 1'b1,
                    $sformatf("rnd%0d", n));
        end

        for (int n = 0; n < 4; n++) begin
            logic [7:0] wds[NUM_REQ];
            mask = NUM_REQ'($urandom_range((1 << NUM_REQ) - 1, 1));
            for (int i = 0; i < NUM_REQ; i++) begin
                wds[i] = 8'($urandom);
                if (mask[i]) set_req(i, 2'b11, 2'd3, wds[i]);
            end
            while (mask != '0) begin
                logic [7:0] mi;
                mi = 8'($urandom);
                w  = model_pick(mask, m_ptr);
                observe(w, 1'b0, 2'd3, {8'h03, wds[w]}, mi, mi, 1'b1,
                        $sformatf("multi%0d-r%0d", n, w));
                mask[w] = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
